// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the CPU inter-stage registers.
//   - pipe_state_t : occupancy state of a pipe_stage_reg (EMPTY / FULL / SKID2)
//   - count_of()   : maps a state to its 2-bit entry count
//   - stage bundle structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t) and their
//     widths, used as the WIDTH parameter of each boundary's stage register.
package pipe_pkg;

  localparam int COUNT_W = 2;

  // The encoding equals the number of held entries, so count is a direct
  // readout of the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID2 = 2'd2
  } pipe_state_t;

  function automatic logic [COUNT_W-1:0] count_of(input pipe_state_t st);
    logic [COUNT_W-1:0] c;
    case (st)
      ST_FULL:  c = 2'd1;
      ST_SKID2: c = 2'd2;
      default:  c = 2'd0;
    endcase
    return c;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with valid/ready handshake.
//
// Parameters:
//   WIDTH - payload width in bits
//   SKID  - 1: two-entry skid buffer, in_ready is registered-state only
//           0: single entry, in_ready passes out_ready through combinationally
// Ports:
//   CLK, RST          - rising-edge clock, asynchronous active-high reset
//   flush             - synchronous squash of all held entries
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and payload
//   count             - entries held (0..2); direct readout of the FSM state
//
// Handshake: a beat moves on a rising edge exactly when valid & ready are both
// high in the preceding cycle. valid never waits on ready, payload is stable
// while valid is high and not yet taken, and flush drops all held beats
// (a beat emitted in the flush cycle is still delivered).
import pipe_pkg::*;

module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter bit SKID  = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept, emit;
  logic             load_main_in, load_main_skid, load_skid;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign count     = count_of(state_q);

  // Skid mode looks only at state, cutting the ready chain between stages.
  assign in_ready = SKID ? ((state_q != ST_SKID2) & ~flush)
                         : (((state_q == ST_EMPTY) | out_ready) & ~flush);

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_FULL;
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && emit) begin
            load_main_in = 1'b1;
          end else if (accept && SKID) begin
            state_d   = ST_SKID2;
            load_skid = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID2: begin
          if (emit) begin
            state_d        = ST_FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
    end
  end

  generate
    if (SKID) begin : g_skid
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          skid_q <= '0;
        end else if (load_skid) begin
          skid_q <= in_data;
        end
      end
    end else begin : g_no_skid
      logic unused_load_skid;
      assign unused_load_skid = load_skid;
      assign skid_q           = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed reset/stream/backpressure/flush/no-skid
// steps on 32-bit instances, then randomized traffic on a 7-bit skid instance
// and a 64-bit single-entry instance against a queue-based reference.
module tb_pipe_stage_reg;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // ---------------- instance signals ----------------
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_count;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [6:0]  c_in_data, c_out_data;
  logic [1:0]  c_count;
  logic        d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [63:0] d_in_data, d_out_data;
  logic [1:0]  d_count;

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1)) u_a (
    .CLK(CLK), .RST(RST), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count));
  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) u_b (
    .CLK(CLK), .RST(RST), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count));
  pipe_stage_reg #(.WIDTH(7), .SKID(1'b1)) u_c (
    .CLK(CLK), .RST(RST), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count));
  pipe_stage_reg #(.WIDTH(64), .SKID(1'b0)) u_d (
    .CLK(CLK), .RST(RST), .flush(d_flush),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .count(d_count));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [6:0]  exp7_q[$];
  logic [63:0] exp64_q[$];
  logic        c_exp_ready, d_exp_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
    d_flush = 0; d_in_valid = 0; d_in_data = '0; d_out_ready = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_all();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // Reset mid-transfer
    a_in_valid = 1; a_in_data = 32'hDEADBEEF;
    tick();
    check("rst_pre_data", a_out_data, 64'hDEADBEEF);
    check("rst_pre_count", a_count, 64'd1);
    #2 RST = 1'b1;
    #1;
    check("rst_out_valid", a_out_valid, 64'd0);
    check("rst_out_data", a_out_data, 64'd0);
    check("rst_count", a_count, 64'd0);
    a_in_valid = 0;
    #1 RST = 1'b0;
    #1;
    check("rst_in_ready", a_in_ready, 64'd1);

    // Streaming 1..8 with out_ready high
    a_out_ready = 1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      a_in_valid = (i <= 8);
      a_in_data  = i;
      #1;
      if (i > 1) begin
        check("stream_valid", a_out_valid, 64'd1);
        check("stream_data", a_out_data, 64'(i - 1));
        check("stream_count", a_count, 64'd1);
        check("stream_in_ready", a_in_ready, 64'd1);
      end
    end
    tick();
    a_in_valid = 0;
    #1;
    check("stream_drain", a_count, 64'd0);

    // Backpressure A, B, C
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hA;
    #1 check("bp_ready0", a_in_ready, 64'd1);
    tick();
    a_in_data = 32'hB;
    #1;
    check("bp_count1", a_count, 64'd1);
    check("bp_ready1", a_in_ready, 64'd1);
    check("bp_data_a", a_out_data, 64'hA);
    tick();
    a_in_data = 32'hC;
    #1;
    check("bp_count2", a_count, 64'd2);
    check("bp_ready2", a_in_ready, 64'd0);
    check("bp_hold_a", a_out_data, 64'hA);
    tick();
    #1;
    check("bp_c_held", a_count, 64'd2);
    a_out_ready = 1;
    #1;
    check("bp_no_comb", a_in_ready, 64'd0);
    tick();
    #1;
    check("bp_out_b", a_out_data, 64'hB);
    check("bp_count_b", a_count, 64'd1);
    check("bp_ready_b", a_in_ready, 64'd1);
    tick();
    a_in_valid = 0;
    #1;
    check("bp_out_c", a_out_data, 64'hC);
    check("bp_count_c", a_count, 64'd1);
    tick();
    #1;
    check("bp_empty", a_count, 64'd0);
    check("bp_empty_valid", a_out_valid, 64'd0);

    // Flush from SKID2
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h11;
    tick();
    a_in_data = 32'h22;
    tick();
    #1 check("fl_count2", a_count, 64'd2);
    a_flush = 1; a_in_data = 32'h33;
    #1 check("fl_in_ready", a_in_ready, 64'd0);
    tick();
    a_flush = 0; a_in_valid = 0;
    #1;
    check("fl_valid", a_out_valid, 64'd0);
    check("fl_count", a_count, 64'd0);
    check("fl_ready_after", a_in_ready, 64'd1);
    tick();
    #1 check("fl_no_33", a_count, 64'd0);

    // Single-entry mode: combinational out_ready -> in_ready
    b_in_valid = 1; b_in_data = 32'h44;
    #1 check("s0_ready_empty", b_in_ready, 64'd1);
    tick();
    b_in_data = 32'h55;
    #1;
    check("s0_ready_blocked", b_in_ready, 64'd0);
    check("s0_count1", b_count, 64'd1);
    check("s0_data_44", b_out_data, 64'h44);
    b_out_ready = 1;
    #1 check("s0_ready_comb", b_in_ready, 64'd1);
    tick();
    b_in_valid = 0; b_out_ready = 0;
    #1;
    check("s0_data_55", b_out_data, 64'h55);
    check("s0_count_max1", b_count, 64'd1);
    b_out_ready = 1;
    tick();
    #1 check("s0_empty", b_count, 64'd0);

    // Randomized traffic on u_c (7-bit, skid) and u_d (64-bit, single entry)
    for (int cyc = 0; cyc < 800; cyc++) begin
      c_in_valid  = 1'($urandom_range(0, 1));
      c_in_data   = 7'($urandom);
      c_out_ready = 1'($urandom_range(0, 1));
      c_flush     = ($urandom_range(0, 15) == 0);
      d_in_valid  = 1'($urandom_range(0, 1));
      d_in_data   = {$urandom, $urandom};
      d_out_ready = 1'($urandom_range(0, 1));
      d_flush     = ($urandom_range(0, 15) == 0);
      #1;
      c_exp_ready = (exp7_q.size() < 2) && !c_flush;
      d_exp_ready = ((exp64_q.size() == 0) || d_out_ready) && !d_flush;
      check("rnd7_in_ready", c_in_ready, 64'(c_exp_ready));
      check("rnd7_out_valid", c_out_valid, 64'(exp7_q.size() != 0));
      check("rnd7_count", c_count, 64'(exp7_q.size()));
      if (exp7_q.size() != 0) check("rnd7_out_data", c_out_data, 64'(exp7_q[0]));
      check("rnd64_in_ready", d_in_ready, 64'(d_exp_ready));
      check("rnd64_out_valid", d_out_valid, 64'(exp64_q.size() != 0));
      check("rnd64_count", d_count, 64'(exp64_q.size()));
      if (exp64_q.size() != 0) check("rnd64_out_data", d_out_data, exp64_q[0]);
      // Advance the reference across the coming edge.
      if (c_out_ready && exp7_q.size() != 0) void'(exp7_q.pop_front());
      if (c_flush) exp7_q.delete();
      else if (c_in_valid && c_exp_ready) exp7_q.push_back(c_in_data);
      if (d_out_ready && exp64_q.size() != 0) void'(exp64_q.pop_front());
      if (d_flush) exp64_q.delete();
      else if (d_in_valid && d_exp_ready) exp64_q.push_back(d_in_data);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
